// File: rtl/expr_pipe_eval_if.sv
// Handshake and lane data bundle for expr_pipe_eval.
// master drives operands and consumes results; slave is the evaluator.
interface expr_pipe_eval_if #(
    parameter int W     = 6,
    parameter int LANES = 6
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [LANES-1:0]     sgn;
    logic [LANES*W-1:0]   a;
    logic [LANES*W-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   y;
    logic [LANES-1:0]     y_ovf;

    modport master (
        output in_valid, op, sgn, a, b, out_ready,
        input  in_ready, out_valid, y, y_ovf
    );

    modport slave (
        input  in_valid, op, sgn, a, b, out_ready,
        output in_ready, out_valid, y, y_ovf
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// Pipelined LANES-wide expression evaluator with valid/ready flow control and overflow counter.
// Define EXPR_PIPE_SAT_EN to make ADD/SUB/MUL clamp on overflow instead of wrapping.
module expr_pipe_eval_lane #(
    parameter int W = 6
) (
    input  logic [3:0]   i_op,
    input  logic         i_sgn,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y,
    output logic         o_ovf
);
    localparam int           P   = 2 * W;
    localparam logic [W-1:0] W_L = W[W-1:0];

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
    localparam logic [3:0] OP_XNR = 4'd4,  OP_SHL = 4'd5, OP_SHR = 4'd6, OP_LT  = 4'd7;
    localparam logic [3:0] OP_EQ  = 4'd8,  OP_MUL = 4'd9, OP_MUX = 4'd10;

    logic         w_ext_a, w_ext_b;
    logic [W:0]   w_ae, w_be, w_sum, w_dif;
    logic [W-1:0] w_shr;
    logic [P-1:0] w_ap, w_bp, w_prod, w_shl;
    logic         w_sum_ov, w_dif_ov, w_mul_ov, w_shl_ov;

    // Exact 2W-bit value does not fit back into W bits of the lane's signedness.
    function automatic logic no_fit(input logic [P-1:0] v, input logic s);
        if (s) return !((&v[P-1:W-1]) || !(|v[P-1:W-1]));
        return |v[P-1:W];
    endfunction

`ifdef EXPR_PIPE_SAT_EN
    function automatic logic [W-1:0] clamp(input logic s, input logic neg);
        if (s) return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return neg ? '0 : '1;
    endfunction
`endif

    assign w_ext_a  = i_sgn & i_a[W-1];
    assign w_ext_b  = i_sgn & i_b[W-1];
    assign w_ae     = {w_ext_a, i_a};
    assign w_be     = {w_ext_b, i_b};
    assign w_ap     = {{W{w_ext_a}}, i_a};
    assign w_bp     = {{W{w_ext_b}}, i_b};
    assign w_sum    = w_ae + w_be;
    assign w_dif    = w_ae - w_be;
    assign w_prod   = w_ap * w_bp;
    assign w_shl    = (i_b >= W_L) ? '0 : (w_ap << i_b);
    assign w_shr    = W'($signed(w_ae) >>> i_b);

    // W+1-bit sum/difference is exact, so the top bit is the true sign (or carry/borrow).
    assign w_sum_ov = i_sgn ? (w_sum[W] ^ w_sum[W-1]) : w_sum[W];
    assign w_dif_ov = i_sgn ? (w_dif[W] ^ w_dif[W-1]) : w_dif[W];
    assign w_mul_ov = no_fit(w_prod, i_sgn);
    assign w_shl_ov = (i_b >= W_L) ? (i_a != '0) : no_fit(w_shl, i_sgn);

    always_comb begin
        o_y   = '0;
        o_ovf = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_y   = w_sum[W-1:0];
                o_ovf = w_sum_ov;
`ifdef EXPR_PIPE_SAT_EN
                if (w_sum_ov) o_y = clamp(i_sgn, i_sgn & w_sum[W]);
`endif
            end
            OP_SUB: begin
                o_y   = w_dif[W-1:0];
                o_ovf = w_dif_ov;
`ifdef EXPR_PIPE_SAT_EN
                if (w_dif_ov) o_y = clamp(i_sgn, !i_sgn | w_dif[W]);
`endif
            end
            OP_AND: o_y = i_a & i_b;
            OP_OR:  o_y = i_a | i_b;
            OP_XNR: o_y = ~(i_a ^ i_b);
            OP_SHL: begin
                o_y   = w_shl[W-1:0];
                o_ovf = w_shl_ov;
            end
            OP_SHR: o_y = w_shr;
            OP_LT:  o_y = {{(W-1){1'b0}}, $signed(w_ae) < $signed(w_be)};
            OP_EQ:  o_y = {{(W-1){1'b0}}, i_a == i_b};
            OP_MUL: begin
                o_y   = w_prod[W-1:0];
                o_ovf = w_mul_ov;
`ifdef EXPR_PIPE_SAT_EN
                if (w_mul_ov) o_y = clamp(i_sgn, i_sgn & w_prod[P-1]);
`endif
            end
            OP_MUX: o_y = (i_a != '0) ? i_b : ~i_b;
            default: ;
        endcase
    end
endmodule

module expr_pipe_eval #(
    parameter int W      = 6,
    parameter int LANES  = 6,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    expr_pipe_eval_if.slave   bus,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  ovf_cnt
);
    localparam int LW = LANES * W;

    logic [LW-1:0]                w_y0;
    logic [LANES-1:0]             w_ovf0;
    logic [STAGES-1:0]            w_rdy;
    logic [STAGES-1:0]            w_src_vld;
    logic [STAGES-1:0][LW-1:0]    w_src_y;
    logic [STAGES-1:0][LANES-1:0] w_src_ovf;
    logic                         w_deliver;
    logic [STAGES-1:0]            r_vld_pipe;
    logic [STAGES-1:0][LW-1:0]    r_y;
    logic [STAGES-1:0][LANES-1:0] r_ovf;
    logic [CNT_W-1:0]             r_cnt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        expr_pipe_eval_lane #(.W(W)) u_lane (
            .i_op  (bus.op),
            .i_sgn (bus.sgn[g]),
            .i_a   (bus.a[(LANES-1-g)*W +: W]),
            .i_b   (bus.b[(LANES-1-g)*W +: W]),
            .o_y   (w_y0[(LANES-1-g)*W +: W]),
            .o_ovf (w_ovf0[g])
        );
    end

    // Stage k can load unless it and every stage after it are full while the sink stalls.
    always_comb begin
        logic w_full;
        w_full = 1'b1;
        w_rdy  = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            w_full   = w_full & r_vld_pipe[k];
            w_rdy[k] = bus.out_ready | ~w_full;
        end
    end

    always_comb begin
        w_src_vld    = '0;
        w_src_y      = '0;
        w_src_ovf    = '0;
        w_src_vld[0] = bus.in_valid;
        w_src_y[0]   = w_y0;
        w_src_ovf[0] = w_ovf0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld_pipe[k-1];
            w_src_y[k]   = r_y[k-1];
            w_src_ovf[k] = r_ovf[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_y        <= '0;
            r_ovf      <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_vld_pipe[k] <= w_src_vld[k];
                    if (w_src_vld[k]) begin
                        r_y[k]   <= w_src_y[k];
                        r_ovf[k] <= w_src_ovf[k];
                    end
                end
            end
        end
    end

    assign w_deliver = r_vld_pipe[STAGES-1] & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr_cnt)
            r_cnt <= '0;
        else if (w_deliver && (|r_ovf[STAGES-1]) && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_vld_pipe[STAGES-1];
    assign bus.y         = r_y[STAGES-1];
    assign bus.y_ovf     = r_ovf[STAGES-1];
    assign ovf_cnt       = r_cnt;
endmodule

// File: doc/expr_pipe_eval.md
Name: expr_pipe_eval

Overview:
- Parametrised, pipelined successor to the fixed-width combinational expression blocks.
- Evaluates one operator on LANES independent lane pairs (a_i, b_i) of width W, with per-lane signed/unsigned interpretation.
- Adds valid/ready handshake, STAGES-deep pipeline with backpressure, per-lane overflow flags and a saturating overflow event counter.
- Serves as a regression target for sequential synthesis and equivalence flows.

Parameters:
W, 6, lane operand/result width (>=2)
LANES, 6, number of lanes
STAGES, 2, pipeline register stages (>=1) = latency in cycles
CNT_W, 16, overflow event counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept this cycle
op  in  4  operator code, common to all lanes
sgn  in  LANES  bit i=1: lane i signed
a  in  LANES*W  lane operands; lane 0 in MSBs
b  in  LANES*W  lane operands; lane 0 in MSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
y  out  LANES*W  lane results; lane 0 in MSBs
y_ovf  out  LANES  per-lane overflow, aligned with y
clr_cnt  in  1  synchronous clear of ovf_cnt
ovf_cnt  out  CNT_W  count of delivered transactions with any y_ovf bit set

Behaviour:
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Operands extend to W+1 bits (sign-extend if sgn[i], else zero-extend); result is truncated to W bits.
- op codes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XNOR.
  - 5 SHL by b unsigned.
  - 6 SHR by b unsigned: arithmetic if sgn[i], logical otherwise. Shift >= W gives 0, or all sign bits when arithmetic.
  - 7 LT with lane signedness, 1-bit zero-extended.
  - 8 EQ (a==b), 1-bit zero-extended.
  - 9 MUL, low W bits.
  - 10 MUX: a!=0 ? b : ~b.
  - 11-15 give 0.
- y_ovf[i]:
  - Set only for ADD, SUB, MUL, SHL when the true result does not fit W bits in the lane's signedness.
  - Unsigned SUB underflow (a<b) counts as overflow.
  - All other ops: 0.
- Compute is combinational into stage 0. Stages 1..STAGES-1 pass data through. Each stage holds a valid bit.
- Stage k advances if stage k+1 is empty or advancing. The last stage advances on out_ready.
- in_ready = !valid[0] || stage0 advancing (combinational from out_ready through the chain; no skid buffer).
- Latency: exactly STAGES cycles from accept to out_valid when unstalled. Throughput 1/cycle. Order is preserved.
- While out_valid && !out_ready, y, y_ovf and out_valid hold stable.
- ovf_cnt:
  - +1 on each delivery with |y_ovf.
  - Saturates at 2^CNT_W-1.
  - clr_cnt wins over a simultaneous increment.
- Reset (any time, including mid-stream):
  - All valid bits, y, y_ovf and ovf_cnt go to 0; in-flight data is dropped.
  - in_ready=1 from the first cycle after rst_n deasserts.

Optional Feature:
EXPR_PIPE_SAT_EN
- Defined:
  - ADD, SUB and MUL saturate on overflow: signed lanes clamp to max/min; unsigned lanes clamp to 2^W-1, or 0 on SUB underflow.
  - y_ovf still reports the overflow.
- Undefined: wrap-around truncation as above.

Test Plan:
- W=6 signed ADD: a0=6'h3D (-3), b0=5 -> y lane0=6'h02, y_ovf=0; out_valid exactly 2 cycles after accept.
- Signed ADD 31+1 -> y=6'h20, y_ovf[0]=1, ovf_cnt=1. Unsigned 63+1 -> y=0, y_ovf=1, ovf_cnt=2. With EXPR_PIPE_SAT_EN: results 6'h1F and 6'h3F.
- SHR, shift 7: signed a=6'h20 -> 6'h3F; unsigned a=6'h20 -> 0. LT, a=6'h3F b=1: signed -> 1, unsigned -> 0.
- out_ready=0 for 6 cycles while 4 transactions are offered:
  - exactly 2 accepted, then in_ready=0;
  - release -> all 4 delivered in order, none lost or duplicated, y stable while stalled.
- Reset mid-stream with 2 in flight -> out_valid=0, y=0 and ovf_cnt=0 immediately; no stale output after release.
- ovf_cnt with CNT_W=2: 5 overflowing deliveries -> saturates at 3. clr_cnt coincident with a 6th -> 0.
